// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Address and twiddle sequencer for an in-place 256-point radix-2 FFT.
// Each cycle it issues one group of four butterflies (eight point
// addresses plus four twiddle indices) to a 4-lane butterfly unit. It
// tracks how many groups are still in flight, and it holds the next
// stage until every write-back of the current stage has landed. This
// avoids the read-after-write hazard of in-place operation.

module fft_stage_sequencer #(
    parameter int STAGES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hold,
    input  logic        wb_valid,
    output logic        issue_valid,
    output logic [63:0] addr_bus,
    output logic [27:0] tw_idx,
    output logic [2:0]  stage,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LAST_STAGE = 3'(STAGES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Address of the top input of butterfly b: a zero bit is inserted at
    // bit position s of b.
    function automatic logic [7:0] top_addr(input logic [6:0] b, input logic [2:0] s);
        logic [7:0] mask;
        mask     = (8'd1 << s) - 8'd1;
        top_addr = ((({1'b0, b} >> s) << ({1'b0, s} + 4'd1)) | ({1'b0, b} & mask));
    endfunction

    // Address of the bottom input, which is the twiddle-multiplied one.
    // It lies one span above the top address.
    function automatic logic [7:0] bot_addr(input logic [6:0] b, input logic [2:0] s);
        bot_addr = top_addr(b, s) + (8'd1 << s);
    endfunction

    // Twiddle index: position within the span, scaled up to the 128-entry table.
    function automatic logic [6:0] tw_of(input logic [6:0] b, input logic [2:0] s);
        logic [7:0] mask;
        mask  = (8'd1 << s) - 8'd1;
        tw_of = 7'((b & mask[6:0]) << (3'd7 - s));
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  cur_stage_r, cur_stage_s;
    logic [4:0]  group_r, group_s;
    logic [5:0]  outstanding_r, outstanding_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        err_r, err_s;
    logic        issue_fire_s;
    logic        issue_valid_r;
    logic [63:0] addr_r, addr_s;
    logic [27:0] tw_r, tw_s;
    logic [2:0]  stage_r;

    // Lane addresses and twiddles for the group that is next to issue.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign addr_s[16*k +: 8]   = top_addr({group_r, 2'(k)}, cur_stage_r);
        assign addr_s[16*k+8 +: 8] = bot_addr({group_r, 2'(k)}, cur_stage_r);
        assign tw_s[7*k +: 7]      = tw_of({group_r, 2'(k)}, cur_stage_r);
    end

    // Next-state, group/stage counters, status flags and in-flight bookkeeping.
    always_comb begin
        state_s       = state_r;
        cur_stage_s   = cur_stage_r;
        group_s       = group_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        err_s         = err_r;
        issue_fire_s  = 1'b0;
        outstanding_s = outstanding_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s     = ISSUE;
                    cur_stage_s = 3'd0;
                    group_s     = 5'd0;
                    busy_s      = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    issue_fire_s = 1'b1;
                    group_s      = group_r + 5'd1;
                    if (group_r == 5'd31) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                // The next stage reads points this stage is still writing.
                if (outstanding_r == 6'd0) begin
                    if (cur_stage_r < LAST_STAGE) begin
                        cur_stage_s = cur_stage_r + 3'd1;
                        group_s     = 5'd0;
                        state_s     = ISSUE;
                    end else begin
                        state_s = FINISH;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end
                end else begin
                    state_s = DRAIN;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase

        // In-flight group count: an issue and a write-back in the same cycle cancel.
        if (issue_fire_s && !wb_valid) begin
            outstanding_s = outstanding_r + 6'd1;
        end else if (!issue_fire_s && wb_valid) begin
            if (outstanding_r == 6'd0) begin
                err_s = 1'b1;
            end else begin
                outstanding_s = outstanding_r - 6'd1;
            end
        end else begin
            outstanding_s = outstanding_r;
        end

        if ((state_r == IDLE) && start) begin
            outstanding_s = 6'd0;
        end else begin
            outstanding_s = outstanding_s;
        end
    end

    // Control state, counters and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            cur_stage_r   <= 3'd0;
            group_r       <= 5'd0;
            outstanding_r <= 6'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            cur_stage_r   <= cur_stage_s;
            group_r       <= group_s;
            outstanding_r <= outstanding_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            err_r         <= err_s;
        end
    end

    // Issue outputs. The addresses, twiddles and stage tag move together and
    // keep their values between issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_valid_r <= 1'b0;
            addr_r        <= 64'd0;
            tw_r          <= 28'd0;
            stage_r       <= 3'd0;
        end else begin
            issue_valid_r <= issue_fire_s;
            if (issue_fire_s) begin
                addr_r  <= addr_s;
                tw_r    <= tw_s;
                stage_r <= cur_stage_r;
            end else begin
                addr_r  <= addr_r;
                tw_r    <= tw_r;
                stage_r <= stage_r;
            end
        end
    end

    assign issue_valid = issue_valid_r;
    assign addr_bus    = addr_r;
    assign tw_idx      = tw_r;
    assign stage       = stage_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer.
// A write-back delay line models the butterfly unit. Every issued group is
// captured and then checked against hand-computed vectors and a reference
// address model.

module tb_fft_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, hold, wb_valid;
    logic        issue_valid;
    logic [63:0] addr_bus;
    logic [27:0] tw_idx;
    logic [2:0]  stage;
    logic        busy, done, err;

    fft_stage_sequencer #(.STAGES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .wb_valid(wb_valid),
        .issue_valid(issue_valid), .addr_bus(addr_bus), .tw_idx(tw_idx),
        .stage(stage), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          s;
        int          g;
        logic [63:0] addr;
        logic [27:0] tw;
    } vec_t;

    vec_t tbl[7];

    int checks = 0;
    int errors = 0;

    logic [63:0] cap_addr[256];
    logic [27:0] cap_tw[256];
    logic [2:0]  cap_stage[256];
    int          n_issue, n_done, wb_seen, hazard_viol, busy_at_done;
    bit          auto_wb;
    logic [2:0]  pipe;

    function automatic logic [63:0] mk_addr(int a0, int a1, int a2, int a3,
                                            int a4, int a5, int a6, int a7);
        mk_addr = {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic logic [27:0] mk_tw(int t0, int t1, int t2, int t3);
        mk_tw = {7'(t3), 7'(t2), 7'(t1), 7'(t0)};
    endfunction

    // Reference model: arithmetic split of b into the part above and below the span.
    function automatic logic [63:0] model_addr(int s, int g);
        int span, b, low, high, top;
        logic [63:0] r;
        r = 64'd0;
        span = 1;
        for (int i = 0; i < s; i++) span = span * 2;
        for (int k = 0; k < 4; k++) begin
            b    = 4 * g + k;
            low  = b % span;
            high = b / span;
            top  = high * 2 * span + low;
            r[16*k +: 8]   = 8'(top);
            r[16*k+8 +: 8] = 8'(top + span);
        end
        model_addr = r;
    endfunction

    function automatic logic [27:0] model_tw(int s, int g);
        int span, b;
        logic [27:0] r;
        r = 28'd0;
        span = 1;
        for (int i = 0; i < s; i++) span = span * 2;
        for (int k = 0; k < 4; k++) begin
            b = 4 * g + k;
            r[7*k +: 7] = 7'((b % span) * (128 / span));
        end
        model_tw = r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs after the edge, then drive the write-back model.
    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_valid) wb_seen++;
        if (issue_valid) begin
            if (n_issue < 256) begin
                cap_addr[n_issue]  = addr_bus;
                cap_tw[n_issue]    = tw_idx;
                cap_stage[n_issue] = stage;
            end
            if ((n_issue % 32 == 0) && (n_issue > 0) && (wb_seen < n_issue)) hazard_viol++;
            n_issue++;
        end
        if (done) begin
            n_done++;
            if (busy) busy_at_done++;
        end
        if (auto_wb) begin
            pipe     = {pipe[1:0], issue_valid};
            wb_valid = pipe[2];
        end
    endtask

    task automatic clear_counts();
        n_issue = 0; n_done = 0; wb_seen = 0; hazard_viol = 0; busy_at_done = 0;
        pipe = 3'd0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("no_issue_on_start", {63'd0, issue_valid}, 64'd0);
    endtask

    // Full transform with optional hold window and a stray start mid-run.
    task automatic run_full(input bit use_hold, input string tag);
        int  c;
        bit  hold_done;
        clear_counts();
        auto_wb   = 1'b1;
        hold_done = 1'b0;
        do_start();
        c = 0;
        while (n_done == 0 && c < 2000) begin
            start = (c == 80) ? 1'b1 : 1'b0;
            if (use_hold && !hold_done && n_issue == 5) begin
                hold = 1'b1;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    check({tag, "_hold_no_issue"}, {63'd0, issue_valid}, 64'd0);
                end
                hold      = 1'b0;
                hold_done = 1'b1;
            end
            tick();
            c++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {63'd0, (n_done != 0)}, 64'd1);
        for (int i = 0; i < 6; i++) tick();
        check({tag, "_issue_count"}, 64'(n_issue), 64'd256);
        check({tag, "_done_count"}, 64'(n_done), 64'd1);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check({tag, "_hazard"}, 64'(hazard_viol), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
        for (int n = 0; n < 256; n++) begin
            if (cap_addr[n] !== model_addr(n / 32, n % 32))
                check({tag, "_seq_addr"}, cap_addr[n], model_addr(n / 32, n % 32));
            if (cap_tw[n] !== model_tw(n / 32, n % 32))
                check({tag, "_seq_tw"}, {36'd0, cap_tw[n]}, {36'd0, model_tw(n / 32, n % 32)});
            if (cap_stage[n] !== 3'(n / 32))
                check({tag, "_seq_stage"}, {61'd0, cap_stage[n]}, 64'(n / 32));
        end
        checks++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_issue_valid"}, {63'd0, issue_valid}, 64'd0);
        check({tag, "_addr_bus"}, addr_bus, 64'd0);
        check({tag, "_tw_idx"}, {36'd0, tw_idx}, 64'd0);
        check({tag, "_stage"}, {61'd0, stage}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
    endtask

    initial begin
        int c;
        tbl[0] = '{0, 0,  mk_addr(0, 1, 2, 3, 4, 5, 6, 7),                  mk_tw(0, 0, 0, 0)};
        tbl[1] = '{1, 0,  mk_addr(0, 2, 1, 3, 4, 6, 5, 7),                  mk_tw(0, 64, 0, 64)};
        tbl[2] = '{7, 0,  mk_addr(0, 128, 1, 129, 2, 130, 3, 131),          mk_tw(0, 1, 2, 3)};
        tbl[3] = '{7, 31, mk_addr(124, 252, 125, 253, 126, 254, 127, 255),  mk_tw(124, 125, 126, 127)};
        tbl[4] = '{2, 0,  mk_addr(0, 4, 1, 5, 2, 6, 3, 7),                  mk_tw(0, 32, 64, 96)};
        tbl[5] = '{0, 31, mk_addr(248, 249, 250, 251, 252, 253, 254, 255),  mk_tw(0, 0, 0, 0)};
        tbl[6] = '{3, 5,  mk_addr(36, 44, 37, 45, 38, 46, 39, 47),          mk_tw(64, 80, 96, 112)};

        rst_n = 1'b0; start = 1'b0; hold = 1'b0; wb_valid = 1'b0; auto_wb = 1'b0;
        clear_counts();
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Free-running transform, then the hand-computed vectors against it.
        run_full(1'b0, "run");
        for (int i = 0; i < 7; i++) begin
            check($sformatf("vec%0d_addr", i), cap_addr[tbl[i].s * 32 + tbl[i].g], tbl[i].addr);
            check($sformatf("vec%0d_tw", i), {36'd0, cap_tw[tbl[i].s * 32 + tbl[i].g]}, {36'd0, tbl[i].tw});
            check($sformatf("vec%0d_stage", i), {61'd0, cap_stage[tbl[i].s * 32 + tbl[i].g]}, 64'(tbl[i].s));
        end

        // Back-pressure early in stage 0.
        run_full(1'b1, "hold");

        // Reset in the middle of stage 3, then a stray write-back.
        clear_counts();
        auto_wb = 1'b1;
        do_start();
        c = 0;
        while (!(issue_valid && stage == 3'd3 && n_issue >= 100) && c < 1000) begin
            tick();
            c++;
        end
        check("reach_stage3", {63'd0, (stage == 3'd3)}, 64'd1);
        auto_wb  = 1'b0;
        wb_valid = 1'b0;
        pipe     = 3'd0;
        rst_n    = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("post_reset_err_clear", {63'd0, err}, 64'd0);
        check("post_reset_idle", {62'd0, busy, issue_valid}, 64'd0);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        check("stray_wb_err", {63'd0, err}, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("err_sticky", {63'd0, err}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("err_cleared_by_reset", {63'd0, err}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
